truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: DWELL, default 20, clock cycles each input vector is held before f is sampled; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; level, sampled on clk.
REQ-005 abort  input  1  synchronous sweep cancel.
REQ-006 f  input  1  output of the 4-input function under test.
REQ-007 a, b, c, d  output  1 each  stimulus vector to function under test; a is MSB, d is LSB.
REQ-008 idx  output  4  index of the vector currently driven; equals {a,b,c,d} while busy.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high when the sweep completed and tt is valid.
REQ-011 tt  output  16  captured truth table; bit i = f sampled with vector i applied.

Function
REQ-012 FSM states IDLE, DRIVE, DONE; single state register, one-hot or binary at implementer's choice.
REQ-013 IDLE or DONE, start=1, abort=0 at edge E0 -> DRIVE from E0; idx=0; busy=1; done=0; tt cleared to 0; dwell counter loaded with DWELL-1.
REQ-014 start while in DRIVE is ignored; no restart, no effect on idx or tt.
REQ-015 DRIVE: each vector held exactly DWELL cycles; counter decrements each edge while nonzero.
REQ-016 On the edge where counter==0: tt[idx] <= f; if idx<15, idx increments and counter reloads DWELL-1; if idx==15, go to DONE.
REQ-017 Sweep latency: done=1 and busy=0 from edge E0+16*DWELL; tt complete at that edge.
REQ-018 DONE: done held high, busy=0, a/b/c/d and idx driven 0, tt held until next accepted start.
REQ-019 abort=1 at any edge in DRIVE or DONE -> IDLE next edge; busy=0, done=0, a/b/c/d=0, idx=0; tt keeps bits already captured.
REQ-020 start and abort both high on same edge: abort wins; state -> IDLE.
REQ-021 IDLE: busy=0, done=0, a/b/c/d=0, idx=0.
REQ-022 DWELL=1: new vector every cycle, f sampled on the edge ending the single-cycle hold; no bubble cycles between vectors.

Reset
REQ-023 rst_n=0 asynchronously forces IDLE, counter=0, idx=0, tt=0, a/b/c/d=0, busy=0, done=0, independent of clk.
REQ-024 Reset asserted mid-sweep discards the sweep; after deassertion block waits in IDLE for a new start.

Configuration
REQ-025 Macro SWEEP_CHECK_EN defined: additional ports exp_tt input 16 (expected table, held stable during sweep), err_cnt output 5, mismatch output 1.
REQ-026 With SWEEP_CHECK_EN: at each sample edge err_cnt increments when f != exp_tt[idx]; err_cnt cleared on accepted start, reset, and abort; mismatch = done && (err_cnt != 0); err_cnt range 0..16, no wrap.
REQ-027 Without SWEEP_CHECK_EN: exp_tt, err_cnt, mismatch ports and associated logic absent; all other behaviour identical.

Verification
REQ-028 DWELL=20, f=a^d, start pulse -> busy 320 cycles, done=1 at E0+320, tt=16'h55AA.
REQ-029 DWELL=1, f tied 0 then f tied 1 (two sweeps) -> done at E0+16 each; tt=16'h0000 then 16'hFFFF; idx steps 0..15 one per cycle.
REQ-030 DWELL=4, start re-pulsed while idx=7, later abort at idx=5 of a new sweep -> first sweep unaffected (done at E0+64); abort gives busy=0, done=0, a/b/c/d=0 next edge, tt[4:0] retained.
REQ-031 rst_n pulsed low mid-cycle at idx=9 -> all outputs 0 immediately without clk edge; no done until new start.
REQ-032 SWEEP_CHECK_EN, f=a^d, exp_tt=16'h55AA -> err_cnt=0, mismatch=0; exp_tt=16'h55AB -> err_cnt=1, mismatch=1 at done.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Walks a..d through all 16 vectors, holding each DWELL cycles and capturing f into tt; done at start+16*DWELL.
// Optional expected-table checker (err_cnt, mismatch) is compiled in with `define SWEEP_CHECK_EN.
module truth_table_sweeper #(
  parameter int DWELL = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef SWEEP_CHECK_EN
  ,
  input  logic [15:0] exp_tt,
  output logic [4:0]  err_cnt,
  output logic        mismatch
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  generate
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("truth_table_sweeper: DWELL must be in 1..255");
    end
  endgenerate

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  idx_q;
  logic [15:0] tt_q;
  logic [15:0] tt_d;
  logic        busy_q;
  logic        done_q;

  // Only the addressed bit changes; the table was cleared when the sweep was accepted.
  always_comb begin
    tt_d        = tt_q;
    tt_d[idx_q] = f;
  end

`ifdef SWEEP_CHECK_EN
  logic [4:0] err_q;
  logic [4:0] err_d;

  always_comb begin
    err_d = err_q;
    if ((f != exp_tt[idx_q]) && (err_q != 5'd16)) begin
      err_d = err_q + 5'd1;
    end
  end

  assign err_cnt  = err_q;
  assign mismatch = done_q && (err_q != 5'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      tt_q    <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_CHECK_EN
      err_q   <= 5'd0;
`endif
    end else if (abort) begin
      // Abort beats a simultaneous start; tt keeps whatever was captured so far.
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_CHECK_EN
      err_q   <= 5'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_DRIVE;
            cnt_q   <= RELOAD;
            idx_q   <= 4'd0;
            tt_q    <= 16'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef SWEEP_CHECK_EN
            err_q   <= 5'd0;
`endif
          end
        end
        S_DRIVE: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            tt_q <= tt_d;
`ifdef SWEEP_CHECK_EN
            err_q <= err_d;
`endif
            if (idx_q != 4'd15) begin
              idx_q <= idx_q + 4'd1;
              cnt_q <= RELOAD;
            end else begin
              state_q <= S_DONE;
              idx_q   <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'd0;
          idx_q   <= 4'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // idx_q is forced to 0 outside DRIVE, so the stimulus is simply the index.
  assign {a, b, c, d} = idx_q;
  assign idx          = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (DWELL 1, 4, 20) driven from a table of functions and expected tables.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic        start_v [3];
  logic        abort_v [3];
  logic        f_v     [3];
  logic        a_v     [3];
  logic        b_v     [3];
  logic        c_v     [3];
  logic        d_v     [3];
  logic [3:0]  idx_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] tt_v    [3];
  int          fsel_v  [3];
`ifdef SWEEP_CHECK_EN
  logic [15:0] exp_tt_v [3];
  logic [4:0]  err_v    [3];
  logic        mism_v   [3];
`endif

  int DW [3] = '{1, 4, 20};
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_sweeper #(.DWELL(g == 0 ? 1 : (g == 1 ? 4 : 20))) u_dut (
      .clk   (clk),
      .rst_n (rst_v[g]),
      .start (start_v[g]),
      .abort (abort_v[g]),
      .f     (f_v[g]),
      .a     (a_v[g]),
      .b     (b_v[g]),
      .c     (c_v[g]),
      .d     (d_v[g]),
      .idx   (idx_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .tt    (tt_v[g])
`ifdef SWEEP_CHECK_EN
      ,
      .exp_tt   (exp_tt_v[g]),
      .err_cnt  (err_v[g]),
      .mismatch (mism_v[g])
`endif
    );
  end

  // Function under test per instance: 0 zero, 1 one, 2 a^d, 3 a&b, 4 c, 5 d
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      f_v[i] = 1'b0;
      case (fsel_v[i])
        1: f_v[i] = 1'b1;
        2: f_v[i] = a_v[i] ^ d_v[i];
        3: f_v[i] = a_v[i] & b_v[i];
        4: f_v[i] = c_v[i];
        5: f_v[i] = d_v[i];
        default: f_v[i] = 1'b0;
      endcase
    end
  end

  typedef struct {
    int          inst;
    int          fsel;
    logic [15:0] exp_tt;
    string       name;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input int i, input string nm);
    chk({nm, "_busy"}, 32'(busy_v[i]), 0);
    chk({nm, "_done"}, 32'(done_v[i]), 0);
    chk({nm, "_idx"}, 32'(idx_v[i]), 0);
    chk({nm, "_abcd"}, 32'({a_v[i], b_v[i], c_v[i], d_v[i]}), 0);
  endtask

  // One complete sweep: latency from the accepting edge, final table, idx walk, DONE outputs.
  task automatic run_sweep(input int i, input int fs, input logic [15:0] exp, input string nm);
    int cyc = 0;
    int bad = 0;
    fsel_v[i] = fs;
    @(negedge clk);
    start_v[i] = 1'b1;
    do begin
      @(negedge clk);
      start_v[i] = 1'b0;
      cyc++;
      if (!done_v[i]) begin
        if (!busy_v[i]) bad++;
        if (idx_v[i] != 4'((cyc - 1) / DW[i])) bad++;
        if ({a_v[i], b_v[i], c_v[i], d_v[i]} != idx_v[i]) bad++;
      end
    end while (!done_v[i] && cyc < 16 * DW[i] + 20);
    chk({nm, "_latency"}, 32'(cyc), 32'(16 * DW[i] + 1));
    chk({nm, "_tt"}, 32'(tt_v[i]), 32'(exp));
    chk({nm, "_walk_errs"}, 32'(bad), 0);
    chk({nm, "_done_busy"}, 32'(busy_v[i]), 0);
    chk({nm, "_done_idx"}, 32'({idx_v[i], a_v[i], b_v[i], c_v[i], d_v[i]}), 0);
  endtask

  initial begin
    int cyc;
    int bad;
    bit pulsed;

    tbl[0] = '{2, 2, 16'h55AA, "d20_a_xor_d"};
    tbl[1] = '{0, 0, 16'h0000, "d1_zero"};
    tbl[2] = '{0, 1, 16'hFFFF, "d1_one"};
    tbl[3] = '{1, 3, 16'hF000, "d4_a_and_b"};
    tbl[4] = '{1, 4, 16'hCCCC, "d4_c"};
    tbl[5] = '{0, 5, 16'hAAAA, "d1_d"};
    tbl[6] = '{0, 2, 16'h55AA, "d1_a_xor_d"};

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; abort_v[i] = 1'b0; fsel_v[i] = 0;
`ifdef SWEEP_CHECK_EN
      exp_tt_v[i] = 16'h0000;
`endif
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_quiet(i, "reset");
      chk("reset_tt", 32'(tt_v[i]), 0);
      rst_v[i] = 1'b1;
    end

    for (int k = 0; k < 7; k++) begin
`ifdef SWEEP_CHECK_EN
      exp_tt_v[tbl[k].inst] = tbl[k].exp_tt;
`endif
      run_sweep(tbl[k].inst, tbl[k].fsel, tbl[k].exp_tt, tbl[k].name);
`ifdef SWEEP_CHECK_EN
      chk({tbl[k].name, "_err_cnt"}, 32'(err_v[tbl[k].inst]), 0);
      chk({tbl[k].name, "_mismatch"}, 32'(mism_v[tbl[k].inst]), 0);
`endif
    end

    // DONE holds, then start+abort together from DONE lands in IDLE with tt kept.
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(done_v[0]), 1);
    chk("done_hold_tt", 32'(tt_v[0]), 32'h55AA);
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk_quiet(0, "start_abort");
    chk("start_abort_tt", 32'(tt_v[0]), 32'h55AA);

    // Re-pulsed start at idx 7 must not disturb the running sweep.
    fsel_v[1] = 2;
    pulsed = 1'b0;
    cyc = 0;
    @(negedge clk);
    start_v[1] = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (idx_v[1] == 4'd7 && !pulsed) begin
        start_v[1] = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_v[1] = 1'b0;
      end
    end while (!done_v[1] && cyc < 100);
    chk("restart_ignored_latency", 32'(cyc), 65);
    chk("restart_ignored_tt", 32'(tt_v[1]), 32'h55AA);

    // Abort at idx 5 of a fresh sweep.
    @(negedge clk);
    start_v[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_v[1] = 1'b0;
      cyc++;
    end while (idx_v[1] != 4'd5 && cyc < 100);
    chk("abort_reach_idx5", 32'(idx_v[1]), 5);
    abort_v[1] = 1'b1;
    @(negedge clk);
    abort_v[1] = 1'b0;
    chk_quiet(1, "abort");
    chk("abort_tt_kept", 32'(tt_v[1]), 32'h000A);

    // Asynchronous reset mid-cycle at idx 9.
    @(negedge clk);
    start_v[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_v[1] = 1'b0;
      cyc++;
    end while (idx_v[1] != 4'd9 && cyc < 100);
    chk("rst_reach_idx9", 32'(idx_v[1]), 9);
    chk("rst_tt_before", 32'(tt_v[1]), 32'h01AA);
    #2 rst_v[1] = 1'b0;
    #1;
    chk_quiet(1, "async_rst");
    chk("async_rst_tt", 32'(tt_v[1]), 0);
    #1 rst_v[1] = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_v[1] || busy_v[1]) bad++;
    end
    chk("rst_stays_idle", 32'(bad), 0);

`ifdef SWEEP_CHECK_EN
    exp_tt_v[0] = 16'h55AB;
    run_sweep(0, 2, 16'h55AA, "chk_bad_exp");
    chk("chk_bad_err_cnt", 32'(err_v[0]), 1);
    chk("chk_bad_mismatch", 32'(mism_v[0]), 1);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("chk_abort_clears_err", 32'(err_v[0]), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
